mdu: RTL
========

// Module: mdu
// PURPOSE
//  Multi-cycle multiply/divide unit with architectural HI/LO registers. It sits in the
//  execute stage beside the ALU and takes the same rs/rt operands as ALU inputs A/B.
//  It serves MULT/MULTU/DIV/DIVU and MTHI/MTLO. HI/LO drive the writeback mux for
//  MFHI/MFLO. busy tells the controller to stall while an operation runs.
// PARAMETERS
//  WIDTH  32  operand/HI/LO width; iteration count = WIDTH
// PORTS
//  clk    in   1      system clock, rising edge
//  rst    in   1      asynchronous, active-high reset
//  start  in   1      launch op; accepted only when busy=0
//  op     in   2      00 MULT, 01 MULTU, 10 DIV, 11 DIVU (sampled with start)
//  A      in   WIDTH  multiplicand / dividend (rs)
//  B      in   WIDTH  multiplier / divisor (rt)
//  hi_we  in   1      MTHI: HI <= wdata
//  lo_we  in   1      MTLO: LO <= wdata
//  wdata  in   WIDTH  MTHI/MTLO data
//  busy   out  1      high while state != IDLE (combinational from state)
//  done   out  1      one-cycle pulse; HI/LO hold the new result in that cycle
//  hi     out  WIDTH  HI register
//  lo     out  WIDTH  LO register
// BEHAVIOUR
//  - Reset (async, any time including mid-op): state=IDLE, count=0, hi=lo=0, done=0,
//    busy=0. All datapath scratch registers are cleared. Operation is lost; no result written.
//  - FSM IDLE -> CALC -> FIN -> IDLE.
//    IDLE: start=1 at edge E0 latches op and the operand magnitudes. For signed ops it
//    also latches the sign flags. count<=0, go to CALC.
//    CALC: one radix-2 step per edge, E1..E32: shift-add for multiply, restoring
//    subtract for divide. At E32 (count==WIDTH-1) go to FIN.
//    FIN: edge E33 applies sign correction, writes HI/LO, done<=1, goes to IDLE.
//  - Latency: result visible and done=1 in the cycle after E33 (34 edges after the
//    start edge). busy=1 from E0 through E33. done=0 on every other cycle.
//  - Multiply: HI:LO = 64-bit product. MULT is signed two's complement; MULTU is unsigned.
//  - Divide: LO=quotient, HI=remainder. DIV truncates toward zero. The quotient is
//    negated when the operand signs differ; the remainder takes the dividend's sign.
//  - DIV 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0 (wraps; no trap).
//  - Divide by zero (DIV or DIVU): LO=0xFFFFFFFF, HI=A as given; no trap; full latency.
//  - start while busy=1: ignored; no effect on the running op.
//  - hi_we/lo_we while busy=1: ignored. The controller must not issue them then.
//  - hi_we/lo_we in IDLE: the register updates at the next edge. If start arrives the
//    same edge, both take effect and the op result overwrites at completion.
//  - A/B may change after the start edge; only the latched copies are used.
//  - HI/LO hold their value at all times except at a FIN edge or an accepted MTHI/MTLO.
// TESTING
//  1 MULT A=0xFFFFFFFD(-3) B=7 -> done at E33+, hi=0xFFFFFFFF lo=0xFFFFFFEB;
//    busy high exactly 34 edges.
//  2 MULTU A=B=0xFFFFFFFF -> hi=0xFFFFFFFE lo=0x00000001.
//  3 DIV A=-7 B=2 -> lo=0xFFFFFFFD hi=0xFFFFFFFF; DIVU A=7 B=2 -> lo=3 hi=1.
//  4 DIVU A=0x1234 B=0 -> lo=0xFFFFFFFF hi=0x1234;
//    DIV A=0x80000000 B=0xFFFFFFFF -> lo=0x80000000 hi=0.
//  5 MULTU 3*5 running, pulse start with MULT 2*2 at E5 and hi_we with 0xDEADBEEF
//    -> both ignored, result hi=0 lo=15. Then MTHI 0xDEADBEEF idle -> hi updates next edge.
//  6 DIVU running, assert rst at E10 -> busy/done/hi/lo = 0 immediately (before the next
//    edge). After release, MULT 6*7 -> lo=42 hi=0.

Source files
------------

// File: rtl/mdu.sv
// Multi-cycle multiply/divide unit with HI/LO registers.
// Radix-2 shift-add multiply and restoring divide on magnitudes, sign fixed at the end.
module mdu #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, CALC, FIN} state_t;

    state_t state, state_nx;

    logic [CW-1:0]    count;
    logic [WIDTH-1:0] acc;      // running product high half / partial remainder
    logic [WIDTH-1:0] qr;       // multiplier shifting out / quotient shifting in
    logic [WIDTH-1:0] ma;       // multiplicand magnitude
    logic [WIDTH-1:0] mb;       // divisor magnitude
    logic             is_div;
    logic             neg_q;
    logic             neg_r;
    logic             div0;

    // operand conditioning at launch
    logic             sgn_op;
    logic             a_neg, b_neg;
    logic [WIDTH-1:0] a_mag, b_mag;

    assign sgn_op = ~op[0];
    assign a_neg  = sgn_op & A[WIDTH-1];
    assign b_neg  = sgn_op & B[WIDTH-1];
    assign a_mag  = a_neg ? -A : A;
    assign b_mag  = b_neg ? -B : B;

    // one iteration of either algorithm
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_sh;
    logic [WIDTH-1:0] div_diff;
    logic             div_ge;
    logic [WIDTH-1:0] acc_nx, qr_nx;

    assign mul_sum  = {1'b0, acc} + {1'b0, (qr[0] ? ma : {WIDTH{1'b0}})};
    assign div_sh   = {acc, qr[WIDTH-1]};
    assign div_ge   = div_sh >= {1'b0, mb};
    // modular subtract is exact whenever div_ge holds, since the result is below mb
    assign div_diff = div_sh[WIDTH-1:0] - mb;

    always_comb begin
        acc_nx = mul_sum[WIDTH:1];
        qr_nx  = {mul_sum[0], qr[WIDTH-1:1]};
        if (is_div) begin
            acc_nx = div_ge ? div_diff : div_sh[WIDTH-1:0];
            qr_nx  = {qr[WIDTH-2:0], div_ge};
        end
    end

    // sign correction and final HI/LO values
    logic [2*WIDTH-1:0] prod, prod_s;
    logic [WIDTH-1:0]   quo_s, rem_s;
    logic [WIDTH-1:0]   res_hi, res_lo;

    assign prod   = {acc, qr};
    assign prod_s = neg_q ? -prod : prod;
    assign quo_s  = neg_q ? -qr : qr;
    assign rem_s  = neg_r ? -acc : acc;

    always_comb begin
        res_hi = prod_s[2*WIDTH-1:WIDTH];
        res_lo = prod_s[WIDTH-1:0];
        if (is_div) begin
            // divide-by-zero leaves |A| in the remainder; sign fix restores A itself
            res_hi = rem_s;
            res_lo = div0 ? {WIDTH{1'b1}} : quo_s;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = CALC;
            CALC:    if (count == LAST) state_nx = FIN;
            FIN:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    assign busy = (state != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count  <= '0;
            acc    <= '0;
            qr     <= '0;
            ma     <= '0;
            mb     <= '0;
            is_div <= 1'b0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            div0   <= 1'b0;
            hi     <= '0;
            lo     <= '0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (hi_we) hi <= wdata;
                    if (lo_we) lo <= wdata;
                    if (start) begin
                        count  <= '0;
                        acc    <= '0;
                        qr     <= op[1] ? a_mag : b_mag;
                        ma     <= a_mag;
                        mb     <= b_mag;
                        is_div <= op[1];
                        neg_q  <= a_neg ^ b_neg;
                        neg_r  <= a_neg;
                        div0   <= op[1] & (B == '0);
                    end
                end
                CALC: begin
                    acc   <= acc_nx;
                    qr    <= qr_nx;
                    count <= count + 1'b1;
                end
                FIN: begin
                    hi   <= res_hi;
                    lo   <= res_lo;
                    done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
